// File: rtl/aes_key_schedule_ctrl.sv
// -----------------------------------------------------------------------------
// aes_key_schedule_ctrl
//   Expands one 128-bit AES cipher key into NROUNDS+1 round keys with a single
//   combinational keygen round, one round per clock. The round keys sit in an
//   internal key store and are served through a registered read port.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request expansion of key_in (accepted when not busy)
//   key_in     cipher key, captured on accepted start
//   busy       expansion in progress
//   keys_valid all round keys stored and stable
//   start_err  one-cycle pulse: start was seen while busy and ignored
//   rd_idx     round key index to read
//   rd_en      read strobe
//   rd_key     round key for rd_idx, valid the cycle after rd_en
//   rd_vld     one-cycle pulse qualifying rd_key
// -----------------------------------------------------------------------------
module aes_key_schedule_ctrl #(
  parameter int NROUNDS = 10,
  parameter int IDX_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [127:0]     key_in,
  output logic             busy,
  output logic             keys_valid,
  output logic             start_err,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic             rd_en,
  output logic [127:0]     rd_key,
  output logic             rd_vld
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] round_cnt;
  logic [127:0]     work;
  logic [127:0]     key_store [0:NROUNDS];
  logic [127:0]     keyout;

  // ---------------------------------------------------------------------------
  // GF(2^8) helpers for the S-box: inverse computed as a^254, then the affine
  // transform. a^254 maps 0 to 0, which is exactly the S-box convention.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] a2, a3, a12, a15, a240, a252, inv;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a12  = gf_mul(gf_mul(a3, a3), gf_mul(a3, a3));
    a15  = gf_mul(a12, a3);
    a240 = gf_mul(a15, a15);            // a^30
    a240 = gf_mul(a240, a240);          // a^60
    a240 = gf_mul(a240, a240);          // a^120
    a240 = gf_mul(a240, a240);          // a^240
    a252 = gf_mul(a240, a12);
    inv  = gf_mul(a252, a2);            // a^254
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [IDX_W-1:0] r);
    logic [7:0] c;
    case (r)
      4'd0:    c = 8'h01;
      4'd1:    c = 8'h02;
      4'd2:    c = 8'h04;
      4'd3:    c = 8'h08;
      4'd4:    c = 8'h10;
      4'd5:    c = 8'h20;
      4'd6:    c = 8'h40;
      4'd7:    c = 8'h80;
      4'd8:    c = 8'h1b;
      4'd9:    c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // One AES-128 key expansion round: w3 is rotated, substituted and mixed with
  // rcon, then the words chain forward by XOR.
  function automatic logic [127:0] keygen(input logic [IDX_W-1:0] r,
                                          input logic [127:0] k);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {sbox(w3[23:16]) ^ rcon(r), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  assign keyout     = keygen(round_cnt, work);
  assign busy       = (state == S_EXPAND);
  assign keys_valid = (state == S_DONE);

  // ---------------------------------------------------------------------------
  // Control, work register and key store
  // ---------------------------------------------------------------------------
  // NOTE: the key store is reset explicitly because a reset mid-expansion must
  // leave no stale round keys readable; this keeps it in flops, not a RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      round_cnt <= '0;
      work      <= '0;
      start_err <= 1'b0;
      for (int i = 0; i <= NROUNDS; i++) key_store[i] <= '0;
    end else begin
      start_err <= 1'b0;
      case (state)
        S_EXPAND: begin
          start_err                    <= start;
          work                         <= keyout;
          key_store[round_cnt + 1'b1]  <= keyout;
          round_cnt                    <= round_cnt + 1'b1;
          if (round_cnt == IDX_W'(NROUNDS - 1)) state <= S_DONE;
        end
        default: begin  // S_IDLE and S_DONE accept a new key identically
          if (start) begin
            state        <= S_EXPAND;
            work         <= key_in;
            key_store[0] <= key_in;
            round_cnt    <= '0;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registered read port. Reading a slot on the same edge it is written yields
  // the old contents, since both sides use the pre-edge store value.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_key <= '0;
      rd_vld <= 1'b0;
    end else begin
      rd_vld <= rd_en;
      if (rd_en) begin
        if (rd_idx > IDX_W'(NROUNDS)) rd_key <= '0;
        else                           rd_key <= key_store[rd_idx];
      end
    end
  end

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_key_schedule_ctrl
//   Randomized scoreboard bench. Expected read data comes from a word-level
//   FIPS-197 key expansion model with a brute-force built S-box; a monitor pops
//   the expected queue whenever rd_vld is seen.
// -----------------------------------------------------------------------------
module tb_aes_key_schedule_ctrl;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy, keys_valid, start_err;
  logic [3:0]   rd_idx;
  logic         rd_en;
  logic [127:0] rd_key;
  logic         rd_vld;

  aes_key_schedule_ctrl #(.NROUNDS(NR), .IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
    .busy(busy), .keys_valid(keys_valid), .start_err(start_err),
    .rd_idx(rd_idx), .rd_en(rd_en), .rd_key(rd_key), .rd_vld(rd_vld)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   sb [0:255];
  logic [127:0] old_k [0:NR];
  logic [127:0] new_k [0:NR];
  int           s_edge = -1000;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h11b << (i - 8));
    return prod[7:0];
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8]
               ^ ((8'h63 >> i) & 8'h01) != 0;
      sb[x] = s;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:4*NR+3];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 4*NR+4; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) new_k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] slot_at(input int i, input int t);
    if (i > NR)            return '0;
    if (t > s_edge + i)    return new_k[i];
    return old_k[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i <= NR; i++) begin old_k[i] = '0; new_k[i] = '0; end
    s_edge = -1000;
  endtask

  // ---------------- scoreboard ----------------
  logic [127:0] exp_q [$];

  always @(negedge clk) begin
    if (rst_n && rd_vld) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL rd_unexpected: rd_vld=1 with nothing outstanding");
      end else begin
        check("rd_key", rd_key, exp_q.pop_front());
      end
    end
  end

  // One cycle of stimulus; inputs are sampled by the next edge (number t).
  task automatic drive(input logic st, input logic [127:0] k, input logic re,
                       input logic [3:0] idx, input bit use_fix, input logic [127:0] fix);
    int t = cyc + 1;
    start = st; key_in = k; rd_en = re; rd_idx = idx;
    if (re) exp_q.push_back(use_fix ? fix : slot_at(int'(idx), t));
    if (st && t > s_edge + NR) begin
      for (int i = 0; i <= NR; i++) old_k[i] = slot_at(i, t);
      expand(k);
      s_edge = t;
    end
    @(posedge clk); #1;
    start = 1'b0; rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 4'd0, 1'b0, '0);
  endtask

  task automatic rd(input logic [3:0] idx);
    drive(1'b0, '0, 1'b1, idx, 1'b0, '0);
  endtask

  task automatic rd_fix(input logic [3:0] idx, input logic [127:0] v);
    drive(1'b0, '0, 1'b1, idx, 1'b1, v);
  endtask

  task automatic count_busy(input string name);
    int n = 0;
    while (busy && n < 50) begin n++; @(posedge clk); #1; end
    check({name, "_busy_cycles"}, 128'(n), 128'(NR));
    check({name, "_keys_valid"}, 128'(keys_valid), 128'(1));
  endtask

  localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;

  initial begin
    logic [127:0] k;
    rst_n = 1'b0; start = 1'b0; key_in = '0; rd_en = 1'b0; rd_idx = '0;
    build_sbox();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_keys_valid", 128'(keys_valid), 128'(0));
    check("rst_rd_vld", 128'(rd_vld), 128'(0));
    check("rst_rd_key", rd_key, '0);
    rst_n = 1'b1;
    idle(1);

    // FIPS-197 A.1 expansion
    drive(1'b1, FIPS_KEY, 1'b0, 4'd0, 1'b0, '0);
    count_busy("fips");
    rd_fix(4'd1,  128'ha0fafe17_88542cb1_23a33939_2a6c7605);
    rd_fix(4'd10, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
    rd_fix(4'd0,  FIPS_KEY);
    rd_fix(4'd15, '0);
    idle(2);

    // start while busy is ignored and flagged
    drive(1'b1, FIPS_KEY, 1'b0, 4'd0, 1'b0, '0);
    idle(3);
    drive(1'b1, 128'hdeadbeef_01234567_89abcdef_55aa55aa, 1'b0, 4'd0, 1'b0, '0);
    check("start_err_pulse", 128'(start_err), 128'(1));
    idle(1);
    check("start_err_clear", 128'(start_err), 128'(0));
    while (busy && cyc < 5000) idle(1);
    check("err_keys_valid", 128'(keys_valid), 128'(1));
    rd_fix(4'd1,  128'ha0fafe17_88542cb1_23a33939_2a6c7605);
    for (int i = 0; i <= NR; i++) rd(4'(i));

    // restart from DONE with an all-zero key
    drive(1'b1, '0, 1'b0, 4'd0, 1'b0, '0);
    check("restart_keys_valid_low", 128'(keys_valid), 128'(0));
    count_busy("zero");
    rd_fix(4'd1, 128'h62636363_62636363_62636363_62636363);
    rd(4'd10);
    idle(2);

    // reset mid-expansion
    drive(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 4'd0, 1'b0, '0);
    idle(4);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_keys_valid", 128'(keys_valid), 128'(0));
    check("midrst_start_err", 128'(start_err), 128'(0));
    check("midrst_rd_key", rd_key, '0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd_fix(4'd3, '0);
    check("postrst_keys_valid", 128'(keys_valid), 128'(0));

    // read-before-write: read the slot being written on every expansion edge
    drive(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 4'd0, 1'b0, '0);
    for (int r = 0; r < NR; r++) rd(4'(r + 1));
    idle(2);
    for (int i = 0; i <= NR; i++) rd(4'(i));

    // random mix of starts and reads in any state
    for (int n = 0; n < 300; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      drive(($urandom_range(0, 15) == 0), k, ($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 15)), 1'b0, '0);
    end
    idle(3);
    check("queue_drained", 128'(exp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
